// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_responder_pkg;

    localparam int MEM_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    function automatic logic addr_bad(input logic [31:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || ({32'd0, addr} >= (64'(depth_words) << 2));
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, mem_byte_en,
        input  mem_resp, mem_rdata, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_byte_en,
        output mem_resp, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word-wide backing store with byte-lane write enables and a registered read.
module mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one level-held request, answers after LATENCY cycles.
// state      | meaning
// ST_IDLE    | waiting for mem_read/mem_write
// ST_WAIT    | latency countdown, inputs ignored
// ST_RESP    | array accessed; response pulse issued on exit
// ST_RELEASE | waiting for the initiator to drop its request
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = MEM_LATENCY_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic          req_err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          resp_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic          req_live;
    logic          in_err;
    logic          enter_resp;
    logic          acc_write;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          arr_rd;
    logic [3:0]    arr_we;
    logic [31:0]   arr_rdata;

    // The array is accessed on the edge entering ST_RESP; with LATENCY=1 that is
    // the acceptance edge itself, so the live bus is used instead of the latch.
    always_comb begin
        req_live   = bus.mem_read | bus.mem_write;
        in_err     = addr_bad(bus.mem_addr, DEPTH_WORDS) | (bus.mem_read & bus.mem_write);
        enter_resp = rst_n & (((state_q == ST_IDLE) & req_live & (LATENCY == 1)) |
                              ((state_q == ST_WAIT) & (cnt_q == 4'd1)));
        if (state_q == ST_IDLE) begin
            acc_write = bus.mem_write;
            acc_err   = in_err;
            acc_idx   = bus.mem_addr[AW+1:2];
            acc_wdata = bus.mem_wdata;
            acc_be    = bus.mem_byte_en;
        end else begin
            acc_write = write_q;
            acc_err   = req_err_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        arr_rd = enter_resp & ~acc_err & ~acc_write;
        arr_we = (enter_resp & ~acc_err & acc_write) ? acc_be : 4'b0000;
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk     (clk),
        .rd_en_i (arr_rd),
        .we_i    (arr_we),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            write_q   <= 1'b0;
            req_err_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            resp_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_live) begin
                        write_q   <= bus.mem_write;
                        req_err_q <= in_err;
                        idx_q     <= bus.mem_addr[AW+1:2];
                        wdata_q   <= bus.mem_wdata;
                        be_q      <= bus.mem_byte_en;
                        if (LATENCY == 1) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_q <= 1'b1;
                    err_q  <= req_err_q;
                    if (req_err_q) begin
                        rdata_q <= '0;
                    end else if (!write_q) begin
                        rdata_q <= arr_rdata;
                    end
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!req_live) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_rdata = rdata_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in backing store (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to mem_resp (legal range 1..15).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mem_read  input  1  read request, level, held by initiator until after mem_resp.
REQ-006 mem_write  input  1  write request, level, held by initiator until after mem_resp.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_byte_en  input  4  write byte lanes; bit i enables wdata[8i+7:8i].
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 mem_rdata  output  32  read data, registered.
REQ-012 mem_err  output  1  error flag, valid only while mem_resp=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP, RELEASE.
REQ-014 IDLE: on edge with mem_read|mem_write=1, latch addr, wdata, byte_en, op; go WAIT with counter=LATENCY-1, or RESP directly if LATENCY=1.
REQ-015 WAIT: decrement counter each cycle; go RESP on the edge where counter=1; request inputs ignored.
REQ-016 Timing: request accepted at edge E0 -> mem_resp=1 for exactly the cycle after edge E_LATENCY.
REQ-017 RESP: mem_resp=1 one cycle; next state RELEASE unconditionally.
REQ-018 RELEASE: stay while mem_read|mem_write=1; go IDLE on first edge with both low; no new request accepted in RELEASE.
REQ-019 Read: mem_rdata loaded with array[word index] on the edge entering RESP; held unchanged until the next RESP entry.
REQ-020 Write: array updated on the edge entering RESP, only enabled byte lanes; mem_rdata unchanged by writes.
REQ-021 Word index = latched addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Error conditions: addr[1:0]!=0, addr>=4*DEPTH_WORDS, or mem_read&mem_write both 1 at acceptance.
REQ-023 On error: mem_resp still pulses at normal latency, mem_err=1 same cycle, no array write, mem_rdata loaded with 0.
REQ-024 Write with mem_byte_en=0000: completes normally, array unchanged, mem_err=0.
REQ-025 mem_err SHALL be 0 whenever mem_resp=0.

Reset
REQ-026 rst_n=0 at any edge: state IDLE, counter 0, mem_resp 0, mem_err 0, mem_rdata 0, latched request cleared.
REQ-027 Reset mid-transaction SHALL abort it: no pending write committed, no mem_resp issued.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 After reset release, a request held high SHALL be accepted from IDLE normally.

Structure
REQ-030 State enum type and MEM_LATENCY_DEFAULT constant SHALL live in the shared datatypes package.
REQ-031 Backing store SHALL be sub-module mem_array: single-port, synchronous, word-wide, per-byte write enable, registered read.
REQ-032 FSM, counter, request latch, error check SHALL reside in mem_responder.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, byte_en 1111, then read 0x10 -> mem_resp exactly 2 cycles after each acceptance, mem_rdata=0xDEADBEEF, mem_err=0.
REQ-034 Array 0x11223344 at 0x20, write 0x000000AA with byte_en 0001, read -> 0x112233AA.
REQ-035 Read 0x22 (misaligned) and 0x1000 (DEPTH 1024) -> mem_resp with mem_err=1, mem_rdata=0, array untouched.
REQ-036 Hold mem_read high 5 cycles past mem_resp -> exactly one mem_resp pulse; next request accepted only after mem_read drops.
REQ-037 Assert rst_n=0 in WAIT of write 0x55555555 to 0x30 -> no mem_resp, subsequent read 0x30 returns prior contents.
REQ-038 LATENCY=1 build: read accepted at E0 -> mem_resp in cycle after E1, mem_rdata held through following cycle.
